ipic_scheduler: RTL and testbench

Sequencing controller for the 4x4 independent parallel indices comparison array. It runs each job in three phases: it loads index rows into the eight index BRAMs, pulses the comparison write strobe for a fixed number of cycles, then drains the sixteen result FIFOs. Draining uses round-robin arbitration onto a single ready/valid output stream. It sits between the host row source and the comparison array, and it owns every `ready`/`write`/`read` strobe the array sees.

---
 rtl/ipic_pkg.sv | 23 ++
 rtl/ipic_scheduler_if.sv | 25 ++
 rtl/ipic_scheduler_arb.sv | 32 +++
 rtl/ipic_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_ipic_scheduler.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ipic_pkg.sv
// Shared types and sizing for the parallel indices comparison sequencer.
// Imported by the scheduler, its arbiter and the result stream interface.
package ipic_pkg;

   localparam int NUM_LANES  = 16;
   localparam int DATA_W     = 32;
   localparam int ROW_W      = 64;
   localparam int LANE_W     = 4;
   localparam int LOAD_BEATS = 8;
   localparam int CMP_CYCLES = 4;
   localparam int BEAT_W     = $clog2(LOAD_BEATS);
   localparam int CMP_W      = $clog2(CMP_CYCLES);
   localparam int CNT_W      = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_COMPARE,
      S_DRAIN,
      S_DONE
   } state_t;

endpackage

// File: rtl/ipic_scheduler_if.sv
// Result stream from the scheduler: registered word, source lane and
// valid/ready handshake.
interface ipic_scheduler_if;
   import ipic_pkg::*;

   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [LANE_W-1:0] out_lane;

   modport master (
      output out_valid,
      output out_data,
      output out_lane,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_data,
      input  out_lane,
      output out_ready
   );

endinterface

// File: rtl/ipic_scheduler_arb.sv
// Combinational 16-way round-robin picker: first requester at or above
// the pointer, wrapping from lane 15 back to lane 0.
module rr_arbiter16
   import ipic_pkg::*;
(
   input  logic [NUM_LANES-1:0] req_i,
   input  logic [LANE_W-1:0]    ptr_i,
   output logic [NUM_LANES-1:0] gnt_o,
   output logic [LANE_W-1:0]    idx_o,
   output logic                 any_o
);

   logic [LANE_W-1:0] cand;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      cand  = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         cand = ptr_i + LANE_W'(i);
         if (!any_o && req_i[cand]) begin
            any_o = 1'b1;
            idx_o = cand;
         end
      end
      if (any_o) begin
         gnt_o[idx_o] = 1'b1;
      end
   end

endmodule

// File: rtl/ipic_scheduler.sv
// Job sequencer for the 4x4 comparison array: load index rows, strobe
// the compare, then drain the result FIFOs round-robin onto one stream.
module ipic_scheduler
   import ipic_pkg::*;
(
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic                        abort,
   input  logic                        row_in_valid,
   output logic                        row_in_ready,
   input  logic [ROW_W-1:0]            row_in,
   output logic                        bram_ready,
   output logic                        bram_rw,
   output logic [ROW_W-1:0]            row_out,
   output logic                        pic_write,
   input  logic [NUM_LANES-1:0]        lane_empty,
   output logic [NUM_LANES-1:0]        lane_rd,
   input  logic [NUM_LANES*DATA_W-1:0] lane_data,
   ipic_scheduler_if.master            out_if,
   output logic                        busy,
   output logic                        done,
   output logic [CNT_W-1:0]            match_count
);

   state_t              state_q, state_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;
   logic [CMP_W-1:0]    cmp_q, cmp_d;
   logic [LANE_W-1:0]   ptr_q, ptr_d;
   logic                pend_q, pend_d;
   logic [LANE_W-1:0]   plane_q, plane_d;
   logic                vld_q, vld_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [LANE_W-1:0]   lane_q, lane_d;
   logic [CNT_W-1:0]    match_q, match_d;

   logic [NUM_LANES-1:0] gnt;
   logic [LANE_W-1:0]    gnt_idx;
   logic                 gnt_any;
   logic                 hs;
   logic                 issue;

   rr_arbiter16 u_arb (
      .req_i (~lane_empty),
      .ptr_i (ptr_q),
      .gnt_o (gnt),
      .idx_o (gnt_idx),
      .any_o (gnt_any)
   );

   assign hs = vld_q && out_if.out_ready;

   // One read in flight at a time and only into a free or draining slot.
   assign issue = (state_q == S_DRAIN) && !abort && gnt_any &&
                  !pend_q && (!vld_q || out_if.out_ready);

   always_comb begin
      state_d      = state_q;
      beat_d       = beat_q;
      cmp_d        = cmp_q;
      ptr_d        = ptr_q;
      pend_d       = pend_q;
      plane_d      = plane_q;
      vld_d        = vld_q;
      data_d       = data_q;
      lane_d       = lane_q;
      match_d      = match_q;
      row_in_ready = 1'b0;
      bram_ready   = 1'b0;
      bram_rw      = 1'b0;
      row_out      = '0;
      pic_write    = 1'b0;
      lane_rd      = '0;
      done         = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_LOAD;
               beat_d  = '0;
               match_d = '0;
               ptr_d   = '0;
            end
         end
         S_LOAD: begin
            row_in_ready = 1'b1;
            if (row_in_valid) begin
               bram_ready = 1'b1;
               bram_rw    = 1'b1;
               row_out    = row_in;
               beat_d     = beat_q + 1'b1;
               if (beat_q == BEAT_W'(LOAD_BEATS - 1)) begin
                  state_d = S_COMPARE;
                  cmp_d   = CMP_W'(CMP_CYCLES - 1);
               end
            end
         end
         S_COMPARE: begin
            bram_ready = 1'b1;
            pic_write  = 1'b1;
            if (cmp_q == '0) begin
               state_d = S_DRAIN;
            end else begin
               cmp_d = cmp_q - 1'b1;
            end
         end
         S_DRAIN: begin
            if (hs) begin
               vld_d = 1'b0;
               if (match_q != '1) begin
                  match_d = match_q + 1'b1;
               end
            end
            if (pend_q) begin
               vld_d  = 1'b1;
               data_d = lane_data[int'(plane_q)*DATA_W +: DATA_W];
               lane_d = plane_q;
               pend_d = 1'b0;
            end
            if (issue) begin
               lane_rd = gnt;
               ptr_d   = gnt_idx + 1'b1;
               pend_d  = 1'b1;
               plane_d = gnt_idx;
            end
            if ((&lane_empty) && !pend_q && !vld_q) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort wins everything and keeps the count from the cut job.
      if (abort) begin
         state_d = S_IDLE;
         vld_d   = 1'b0;
         pend_d  = 1'b0;
         match_d = match_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         beat_q  <= '0;
         cmp_q   <= '0;
         ptr_q   <= '0;
         pend_q  <= 1'b0;
         plane_q <= '0;
         vld_q   <= 1'b0;
         data_q  <= '0;
         lane_q  <= '0;
         match_q <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         cmp_q   <= cmp_d;
         ptr_q   <= ptr_d;
         pend_q  <= pend_d;
         plane_q <= plane_d;
         vld_q   <= vld_d;
         data_q  <= data_d;
         lane_q  <= lane_d;
         match_q <= match_d;
      end
   end

   assign out_if.out_valid = vld_q;
   assign out_if.out_data  = data_q;
   assign out_if.out_lane  = lane_q;
   assign busy             = (state_q != S_IDLE);
   assign match_count      = match_q;

endmodule

// File: tb/tb_ipic_scheduler.sv
// Directed bench for ipic_scheduler with a small registered-read FIFO
// model standing in for the sixteen result FIFOs.
module tb_ipic_scheduler;
   import ipic_pkg::*;

   logic                        clk = 1'b0;
   logic                        reset = 1'b0;
   logic                        start = 1'b0;
   logic                        abort = 1'b0;
   logic                        row_in_valid = 1'b0;
   logic                        row_in_ready;
   logic [ROW_W-1:0]            row_in = '0;
   logic                        bram_ready;
   logic                        bram_rw;
   logic [ROW_W-1:0]            row_out;
   logic                        pic_write;
   logic [NUM_LANES-1:0]        lane_empty;
   logic [NUM_LANES-1:0]        lane_rd;
   logic [NUM_LANES*DATA_W-1:0] lane_data;
   logic                        busy;
   logic                        done;
   logic [CNT_W-1:0]            match_count;

   ipic_scheduler_if oif ();

   logic [DATA_W-1:0] mem [NUM_LANES][8];
   logic [DATA_W-1:0] ldq [NUM_LANES] = '{default: '0};
   int                head [NUM_LANES] = '{default: 0};
   int                cnt  [NUM_LANES] = '{default: 0};
   int                cyc = 0;
   int                npass = 0;
   int                ntot = 0;

   int                rd_cyc [$];
   int                got_lane [$];
   logic [DATA_W-1:0] got_data [$];

   ipic_scheduler dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .abort        (abort),
      .row_in_valid (row_in_valid),
      .row_in_ready (row_in_ready),
      .row_in       (row_in),
      .bram_ready   (bram_ready),
      .bram_rw      (bram_rw),
      .row_out      (row_out),
      .pic_write    (pic_write),
      .lane_empty   (lane_empty),
      .lane_rd      (lane_rd),
      .lane_data    (lane_data),
      .out_if       (oif),
      .busy         (busy),
      .done         (done),
      .match_count  (match_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      for (int i = 0; i < NUM_LANES; i++) begin
         if (lane_rd[i]) begin
            ldq[i]  <= mem[i][head[i] % 8];
            head[i] <= head[i] + 1;
         end
      end
   end

   always_comb begin
      lane_empty = '0;
      lane_data  = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         lane_empty[i] = (head[i] >= cnt[i]);
         lane_data[i*DATA_W +: DATA_W] = ldq[i];
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic push(input int l, input logic [DATA_W-1:0] d);
      mem[l][cnt[l] % 8] = d;
      cnt[l]++;
   endtask

   task automatic start_job(output int s);
      @(negedge clk);
      start = 1'b1;
      s = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic load_rows(input int gap_after, input bit check);
      for (int k = 1; k <= LOAD_BEATS; k++) begin
         row_in_valid = 1'b1;
         row_in = 64'(k);
         #1;
         if (check) begin
            chk($sformatf("row_out_%0d", k), row_out, 64'(k));
            chk($sformatf("bram_wr_%0d", k), {bram_ready, bram_rw}, 2'b11);
         end
         @(negedge clk);
         if (k == gap_after) begin
            row_in_valid = 1'b0;
            #1;
            chk("gap_bram_ready", bram_ready, 1'b0);
            @(negedge clk);
         end
      end
      row_in_valid = 1'b0;
   endtask

   task automatic wait_done(output int dcyc, output int pw);
      bit found;
      found = 1'b0;
      dcyc = -1;
      pw = 0;
      for (int i = 0; i < 60; i++) begin
         if (pic_write) pw++;
         if (done) begin
            found = 1'b1;
            dcyc = cyc;
            break;
         end
         @(negedge clk);
      end
      chk("done_seen", found, 1'b1);
   endtask

   task automatic wait_valid(input string tag);
      for (int i = 0; i < 40 && !oif.out_valid; i++) @(negedge clk);
      chk(tag, oif.out_valid, 1'b1);
   endtask

   task automatic run_drain();
      bit found;
      found = 1'b0;
      rd_cyc.delete();
      got_lane.delete();
      got_data.delete();
      for (int i = 0; i < 80; i++) begin
         if (lane_rd != '0) begin
            rd_cyc.push_back(cyc);
         end
         if (oif.out_valid && oif.out_ready) begin
            got_lane.push_back(int'(oif.out_lane));
            got_data.push_back(oif.out_data);
         end
         if (done) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("drain_done", found, 1'b1);
   endtask

   initial begin
      int  s;
      int  d;
      int  pw;
      bit  stable;
      bit  rdseen;
      bit  held;
      bit  dseen;
      logic [DATA_W-1:0] d0;

      oif.out_ready = 1'b0;

      // Power-on reset
      repeat (2) @(negedge clk);
      chk("rst_ctl", {row_in_ready, bram_ready, bram_rw, pic_write,
                      busy, done, oif.out_valid}, '0);
      chk("rst_row_out", row_out, '0);
      chk("rst_lane_rd", lane_rd, '0);
      chk("rst_out", {oif.out_data, 4'(oif.out_lane)}, '0);
      chk("rst_match", match_count, '0);
      reset = 1'b1;

      // Reset asserted mid-LOAD after beat 3
      start_job(s);
      chk("start_busy", {busy, row_in_ready}, 2'b11);
      for (int k = 1; k <= 3; k++) begin
         row_in_valid = 1'b1;
         row_in = 64'(k);
         @(negedge clk);
      end
      row_in = 64'h4;
      #2 reset = 1'b0;
      #1;
      chk("midrst_ctl", {row_in_ready, bram_ready, bram_rw, busy}, '0);
      chk("midrst_row_out", row_out, '0);
      @(negedge clk);
      row_in_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_idle", {busy, row_in_ready}, 2'b00);

      // Full load, gap after beat 2, no matches
      start_job(s);
      load_rows(2, 1'b1);
      wait_done(d, pw);
      chk("pic_write_cycles", 64'(pw), 64'd4);
      chk("done_latency", 64'(d - s), 64'd15);
      chk("empty_match", match_count, '0);
      @(negedge clk);
      chk("after_done_idle", {busy, done}, 2'b00);

      // Lanes 3,7,12 with 2,1,1 words, out_ready high
      push(3, 32'hA300_0001);
      push(3, 32'hA300_0002);
      push(7, 32'hB700_0001);
      push(12, 32'hCC00_0001);
      oif.out_ready = 1'b1;
      start_job(s);
      load_rows(0, 1'b0);
      run_drain();
      chk("rr_count", 64'(got_lane.size()), 64'd4);
      chk("rr_lane0", 64'(got_lane[0]), 64'd3);
      chk("rr_lane1", 64'(got_lane[1]), 64'd7);
      chk("rr_lane2", 64'(got_lane[2]), 64'd12);
      chk("rr_lane3", 64'(got_lane[3]), 64'd3);
      chk("rr_data0", got_data[0], 32'hA300_0001);
      chk("rr_data3", got_data[3], 32'hA300_0002);
      chk("rr_data2", got_data[2], 32'hCC00_0001);
      chk("rd_count", 64'(rd_cyc.size()), 64'd4);
      chk("rd_gap1", 64'(rd_cyc[1] - rd_cyc[0]), 64'd2);
      chk("rd_gap2", 64'(rd_cyc[2] - rd_cyc[1]), 64'd2);
      chk("rd_gap3", 64'(rd_cyc[3] - rd_cyc[2]), 64'd2);
      chk("rr_match", match_count, 16'd4);

      // Backpressure with 5 stalled cycles
      push(0, 32'hD000_0001);
      push(0, 32'hD000_0002);
      push(5, 32'hE500_0001);
      oif.out_ready = 1'b0;
      start_job(s);
      load_rows(0, 1'b0);
      wait_valid("bp_valid");
      d0 = oif.out_data;
      chk("bp_first", d0, 32'hD000_0001);
      stable = 1'b1;
      rdseen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (oif.out_data !== d0 || !oif.out_valid) stable = 1'b0;
         if (lane_rd != '0) rdseen = 1'b1;
      end
      chk("bp_stable", stable, 1'b1);
      chk("bp_no_rd", rdseen, 1'b0);
      oif.out_ready = 1'b1;
      run_drain();
      chk("bp_count", 64'(got_data.size()), 64'd3);
      chk("bp_w0", got_data[0], 32'hD000_0001);
      chk("bp_w1", got_data[1], 32'hE500_0001);
      chk("bp_w2", got_data[2], 32'hD000_0002);
      chk("bp_match", match_count, 16'd3);

      // Pointer parked at 14, then lanes 1 and 15 filled
      push(13, 32'h1300_0001);
      oif.out_ready = 1'b0;
      start_job(s);
      load_rows(0, 1'b0);
      wait_valid("wrap_valid");
      chk("wrap_first_lane", oif.out_lane, 4'd13);
      push(1, 32'h0100_0001);
      push(15, 32'h1500_0001);
      @(negedge clk);
      oif.out_ready = 1'b1;
      run_drain();
      chk("wrap_count", 64'(got_lane.size()), 64'd3);
      chk("wrap_lane1", 64'(got_lane[1]), 64'd15);
      chk("wrap_lane2", 64'(got_lane[2]), 64'd1);
      chk("wrap_data2", got_data[2], 32'h0100_0001);

      // Abort during DRAIN with a word held
      push(2, 32'h0200_0001);
      oif.out_ready = 1'b0;
      start_job(s);
      load_rows(0, 1'b0);
      wait_valid("abort_valid");
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_state", {busy, oif.out_valid, done}, 3'b000);
      chk("abort_match", match_count, 16'd0);
      dseen = 1'b0;
      held = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done) dseen = 1'b1;
         if (busy || lane_rd != '0) held = 1'b0;
      end
      chk("abort_no_done", dseen, 1'b0);
      chk("abort_idle", held, 1'b1);
      oif.out_ready = 1'b1;
      start_job(s);
      chk("restart_busy", busy, 1'b1);
      load_rows(0, 1'b0);
      wait_done(d, pw);
      chk("restart_latency", 64'(d - s), 64'd14);
      chk("restart_match", match_count, 16'd0);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
